// File: rtl/debug_loader.sv
// Byte-stream program loader: decodes commands, assembles little-endian
// words, drives debug imem/dmem write ports and releases core reset.
module debug_loader #(
  parameter logic [7:0]  CMD_IMEM   = 8'h01,
  parameter logic [7:0]  CMD_DMEM   = 8'h02,
  parameter logic [7:0]  CMD_RUN    = 8'h03,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        core_rst,
  output logic [31:0] rst_addr,
  output logic        debug_imem_oe,
  output logic        debug_imem_we,
  output logic [31:0] debug_imem_addr,
  output logic [31:0] debug_imem_data,
  output logic        debug_dmem_oe,
  output logic        debug_dmem_we,
  output logic [31:0] debug_dmem_addr,
  output logic [31:0] debug_dmem_data,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CNT,
    S_DATA,
    S_RUN
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [31:0] sh;
  logic [31:0] addr_reg;
  logic [15:0] cnt;
  logic        tgt_dmem;
  logic        run_flag;
  logic        xfer;
  logic [31:0] word;

  // Bytes shift in from the top so the first byte lands in [7:0].
  assign word     = {in_data, sh[31:8]};
  assign in_ready = (state != S_RUN);
  assign xfer     = in_valid & in_ready;
  assign busy     = (state == S_ADDR) || (state == S_CNT) ||
                    (state == S_DATA) || debug_imem_we ||
                    debug_dmem_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      idx             <= 2'd0;
      sh              <= 32'd0;
      addr_reg        <= 32'd0;
      cnt             <= 16'd0;
      tgt_dmem        <= 1'b0;
      run_flag        <= 1'b0;
      err             <= 1'b0;
      core_rst        <= 1'b1;
      rst_addr        <= RESET_ADDR;
      debug_imem_oe   <= 1'b1;
      debug_imem_we   <= 1'b0;
      debug_imem_addr <= 32'd0;
      debug_imem_data <= 32'd0;
      debug_dmem_oe   <= 1'b1;
      debug_dmem_we   <= 1'b0;
      debug_dmem_addr <= 32'd0;
      debug_dmem_data <= 32'd0;
    end else begin
      debug_imem_we <= 1'b0;
      debug_dmem_we <= 1'b0;
      if (xfer) begin
        sh <= word;
        unique case (state)
          S_IDLE: begin
            idx <= 2'd0;
            if (in_data == CMD_IMEM ||
                in_data == CMD_DMEM) begin
              tgt_dmem <= (in_data == CMD_DMEM);
              run_flag <= 1'b0;
              state    <= S_ADDR;
            end else if (in_data == CMD_RUN) begin
              run_flag <= 1'b1;
              state    <= S_ADDR;
            end else begin
              err <= 1'b1;
            end
          end
          S_ADDR: begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              addr_reg <= word;
              if (run_flag) begin
                state         <= S_RUN;
                core_rst      <= 1'b0;
                rst_addr      <= word;
                debug_imem_oe <= 1'b0;
                debug_dmem_oe <= 1'b0;
              end else begin
                state <= S_CNT;
              end
            end
          end
          S_CNT: begin
            idx <= idx + 2'd1;
            if (idx == 2'd1) begin
              idx   <= 2'd0;
              cnt   <= word[31:16];
              state <= (word[31:16] == 16'd0) ?
                       S_IDLE : S_DATA;
            end
          end
          S_DATA: begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              if (tgt_dmem) begin
                debug_dmem_we   <= 1'b1;
                debug_dmem_addr <= addr_reg;
                debug_dmem_data <= word;
              end else begin
                debug_imem_we   <= 1'b1;
                debug_imem_addr <= addr_reg;
                debug_imem_data <= word;
              end
              addr_reg <= addr_reg + 32'd4;
              cnt      <= cnt - 16'd1;
              if (cnt == 16'd1) state <= S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debug_loader.sv
// Self-checking bench for debug_loader: vector table, corner sequences
// and randomized streams against a stream-parsing reference model.
module tb_debug_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        core_rst;
  logic [31:0] rst_addr;
  logic        debug_imem_oe;
  logic        debug_imem_we;
  logic [31:0] debug_imem_addr;
  logic [31:0] debug_imem_data;
  logic        debug_dmem_oe;
  logic        debug_dmem_we;
  logic [31:0] debug_dmem_addr;
  logic [31:0] debug_dmem_data;
  logic        busy;
  logic        err;

  debug_loader dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .core_rst        (core_rst),
    .rst_addr        (rst_addr),
    .debug_imem_oe   (debug_imem_oe),
    .debug_imem_we   (debug_imem_we),
    .debug_imem_addr (debug_imem_addr),
    .debug_imem_data (debug_imem_data),
    .debug_dmem_oe   (debug_dmem_oe),
    .debug_dmem_we   (debug_dmem_we),
    .debug_dmem_addr (debug_dmem_addr),
    .debug_dmem_data (debug_dmem_data),
    .busy            (busy),
    .err             (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mem;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct packed {
    logic [0:15][7:0] b;
    int               len;
    int               n;
    bit               mem;
    logic [31:0]      a0;
    logic [31:0]      d0;
    logic [31:0]      a1;
    logic [31:0]      d1;
    bit               e;
    bit               run;
    logic [31:0]      ra;
  } vec_t;

  int checks = 0;
  int failures = 0;

  wr_t obs[$];
  wr_t exp_q[$];
  logic [7:0] strm[$];
  bit exp_err;
  bit exp_run;
  logic [31:0] exp_ra;

  always @(negedge clk) begin
    if (debug_imem_we && debug_dmem_we) begin
      checks++;
      failures++;
      $display("FAIL both_we imem_we=1 dmem_we=1 required one at most");
    end
    if (debug_imem_we)
      obs.push_back('{mem: 1'b0, a: debug_imem_addr, d: debug_imem_data});
    if (debug_dmem_we)
      obs.push_back('{mem: 1'b1, a: debug_dmem_addr, d: debug_dmem_data});
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tick(gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick(2);
    rst = 1'b0;
    obs.delete();
  endtask

  task automatic chk_reset_vals(input string t);
    chk({t, "_in_ready"}, in_ready, 1);
    chk({t, "_core_rst"}, core_rst, 1);
    chk({t, "_rst_addr"}, rst_addr, 0);
    chk({t, "_imem_oe"}, debug_imem_oe, 1);
    chk({t, "_dmem_oe"}, debug_dmem_oe, 1);
    chk({t, "_imem_we"}, debug_imem_we, 0);
    chk({t, "_dmem_we"}, debug_dmem_we, 0);
    chk({t, "_imem_ad"}, {debug_imem_addr, debug_imem_data}, 0);
    chk({t, "_dmem_ad"}, {debug_dmem_addr, debug_dmem_data}, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_err"}, err, 0);
  endtask

  function automatic logic [31:0] le32(input int i);
    return 32'(strm[i]) + (32'(strm[i+1]) << 8) +
           (32'(strm[i+2]) << 16) + (32'(strm[i+3]) << 24);
  endfunction

  // Reference: walk the whole command stream and list the writes it implies.
  function automatic void model();
    int i;
    int n;
    logic [31:0] base;
    exp_q.delete();
    exp_err = 0;
    exp_run = 0;
    exp_ra  = 0;
    i = 0;
    while (i < strm.size()) begin
      if (strm[i] == 8'h01 || strm[i] == 8'h02) begin
        base = le32(i + 1);
        n = int'(strm[i+5]) + 256 * int'(strm[i+6]);
        for (int k = 0; k < n; k++)
          exp_q.push_back('{mem: (strm[i] == 8'h02),
                            a: base + 32'(4 * k),
                            d: le32(i + 7 + 4 * k)});
        i += 7 + 4 * n;
      end else if (strm[i] == 8'h03) begin
        exp_run = 1;
        exp_ra  = le32(i + 1);
        break;
      end else begin
        exp_err = 1;
        i++;
      end
    end
  endfunction

  task automatic cmp_writes(input string t);
    chk({t, "_nwr"}, obs.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs.size(); k++) begin
      chk($sformatf("%s_mem%0d", t, k), obs[k].mem, exp_q[k].mem);
      chk($sformatf("%s_ad%0d", t, k), {obs[k].a, obs[k].d},
          {exp_q[k].a, exp_q[k].d});
    end
  endtask

  vec_t vt[5];

  initial begin
    vt[0] = '{b: {8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00,
                  8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD,
                  8'hDE, {1{8'h00}}},
              len: 15, n: 2, mem: 0, a0: 32'h1000, d0: 32'h12345678,
              a1: 32'h1004, d1: 32'hDEADBEEF, e: 0, run: 0, ra: 0};
    vt[1] = '{b: {8'h02, 8'h00, 8'h00, 8'h00, 8'h80, 8'h01, 8'h00,
                  8'h04, 8'h03, 8'h02, 8'h01, {5{8'h00}}},
              len: 11, n: 1, mem: 1, a0: 32'h80000000, d0: 32'h01020304,
              a1: 0, d1: 0, e: 0, run: 0, ra: 0};
    vt[2] = '{b: {8'h03, 8'h00, 8'h02, 8'h00, 8'h00, {11{8'h00}}},
              len: 5, n: 0, mem: 0, a0: 0, d0: 0, a1: 0, d1: 0,
              e: 0, run: 1, ra: 32'h200};
    vt[3] = '{b: {8'hFF, 8'h01, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02,
                  8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                  8'h77, 8'h88},
              len: 16, n: 2, mem: 0, a0: 32'hFFFFFFFC, d0: 32'h44332211,
              a1: 32'h0, d1: 32'h88776655, e: 1, run: 0, ra: 0};
    vt[4] = '{b: {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, {4{8'h00}}},
              len: 12, n: 0, mem: 0, a0: 0, d0: 0, a1: 0, d1: 0,
              e: 0, run: 1, ra: 32'hDDCCBBAA};

    do_reset();
    chk_reset_vals("rst0");

    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int i = 0; i < vt[v].len; i++) send(vt[v].b[i], 0);
      tick(3);
      chk($sformatf("v%0d_nwr", v), obs.size(), vt[v].n);
      if (obs.size() > 0) begin
        chk($sformatf("v%0d_mem0", v), obs[0].mem, vt[v].mem);
        chk($sformatf("v%0d_w0", v), {obs[0].a, obs[0].d},
            {vt[v].a0, vt[v].d0});
      end
      if (obs.size() > 1)
        chk($sformatf("v%0d_w1", v), {obs[1].a, obs[1].d},
            {vt[v].a1, vt[v].d1});
      chk($sformatf("v%0d_err", v), err, vt[v].e);
      chk($sformatf("v%0d_core_rst", v), core_rst, !vt[v].run);
      chk($sformatf("v%0d_rst_addr", v), rst_addr, vt[v].ra);
      chk($sformatf("v%0d_in_ready", v), in_ready, !vt[v].run);
      chk($sformatf("v%0d_oe", v), {debug_imem_oe, debug_dmem_oe},
          vt[v].run ? 2'b00 : 2'b11);
      chk($sformatf("v%0d_busy", v), busy, 0);
    end

    // Held partial field, then one-cycle write pulse and hold afterwards.
    do_reset();
    send(8'h01, 0);
    send(8'h10, 0);
    send(8'h00, 8);
    chk("hold_busy", busy, 1);
    chk("hold_ready", in_ready, 1);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h11, 5);
    send(8'h22, 5);
    send(8'h33, 5);
    chk("pulse_pre", debug_imem_we, 0);
    send(8'h44, 0);
    chk("pulse_we", debug_imem_we, 1);
    chk("pulse_busy", busy, 1);
    tick(1);
    chk("pulse_end", debug_imem_we, 0);
    chk("pulse_busy_end", busy, 0);
    chk("pulse_hold", {debug_imem_addr, debug_imem_data},
        {32'h10, 32'h44332211});
    chk("pulse_dmem", debug_dmem_we, 0);

    // RUN edge timing and ignored bytes afterwards.
    do_reset();
    send(8'h03, 0);
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h00, 0);
    in_valid = 1'b1;
    in_data  = 8'h00;
    #3;
    chk("run_pre_core_rst", core_rst, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("run_core_rst", core_rst, 0);
    chk("run_rst_addr", rst_addr, 32'h200);
    for (int i = 0; i < 8; i++) send(8'(i == 0 ? 1 : i * 17), 0);
    tick(2);
    chk("run_ignore_addr", rst_addr, 32'h200);
    chk("run_ignore_core", core_rst, 0);
    chk("run_ignore_wr", obs.size(), 0);
    chk("run_ready", in_ready, 0);

    // Reset in the middle of a word.
    do_reset();
    send(8'hFF, 0);
    chk("mid_err_set", err, 1);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_reset_vals("mid");
    obs.delete();
    send(8'h02, 0);
    send(8'h40, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 0);
    send(8'h04, 0);
    tick(3);
    chk("mid_nwr", obs.size(), 1);
    if (obs.size() > 0)
      chk("mid_w", {obs[0].mem, obs[0].a, obs[0].d},
          {1'b1, 32'h40, 32'h04030201});

    // Randomized streams against the model.
    for (int it = 0; it < 25; it++) begin
      do_reset();
      strm.delete();
      for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
        int kind;
        int n;
        logic [31:0] a;
        kind = int'($urandom_range(0, 4));
        if (kind == 0) begin
          logic [7:0] bb;
          bb = 8'($urandom_range(0, 252));
          if (bb != 0) bb = bb + 8'd3;
          strm.push_back(bb);
        end else begin
          a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : $urandom;
          n = int'($urandom_range(0, 3));
          strm.push_back(kind <= 2 ? 8'h01 : 8'h02);
          for (int k = 0; k < 4; k++) strm.push_back(a[8*k +: 8]);
          strm.push_back(8'(n));
          strm.push_back(8'h00);
          for (int k = 0; k < 4 * n; k++) strm.push_back(8'($urandom));
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] ra;
        ra = $urandom;
        strm.push_back(8'h03);
        for (int k = 0; k < 4; k++) strm.push_back(ra[8*k +: 8]);
        for (int k = 0; k < 3; k++) strm.push_back(8'h01);
      end
      model();
      for (int i = 0; i < strm.size(); i++)
        send(strm[i], int'($urandom_range(0, 2)));
      tick(3);
      cmp_writes($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_err", it), err, exp_err);
      chk($sformatf("rnd%0d_core_rst", it), core_rst, !exp_run);
      chk($sformatf("rnd%0d_rst_addr", it), rst_addr, exp_ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
